adas_long_ctrl: RTL and testbench
=================================

# adas_long_ctrl

Parametrised longitudinal controller for the ADAS top level. It fuses lidar and camera distance into a windowed moving average and detects persistent sensor disagreement. A four-state FSM drives gas/brake from the speed and following-distance targets. It replaces the fixed 8-bit, 4-sample controller and sits between the car sensor bus and the actuator interface.

## Interface
- W, 8: width of all distance and speed buses.
- DEPTH_LOG2, 2: log2 of the averaging window depth (window = 2^DEPTH_LOG2 samples).
- DIFF_THR, 20: sensor disagreement threshold, |cam − lidar|.
- FAULT_TICKS, 4: consecutive disagreeing ticks needed to raise a fault.
- HYST, 2: hysteresis band for speed and distance compares.
- DEF_SPEED, 100 / DEF_DIST, 50 / ZONE_SPEED, 20: default speed, default distance and crosswalk speed targets.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- tick_i  in  1  control-period strobe; state advances only on edges where it is 1.
- mode_i  in  1  1 = autonomous, 0 = assist.
- redlight_i, crosswalk_i  in  2 each  bit1 = lidar detect, bit0 = camera detect.
- dist_lidar_i, dist_cam_i, speed_meas_i  in  W each  measured values.
- speed_set_i, dist_set_i  in  W each  user setpoints; 0 selects the default.
- gas_o, brake_o  out  1 each  actuator commands; {1,1} = hold speed.
- redlight_o, crosswalk_o  out  1 each  AND of both detect bits.
- dist_o  out  W  filtered following distance.
- dist_valid_o  out  1  window full.
- sensor_fault_o  out  1  persistent disagreement.
- state_o  out  2  FSM state.

## Operation
- **Fusion.** diff = |cam − lidar|, computed in W+1 bits.
  - diff > DIFF_THR: sample = lidar.
  - Otherwise: sample = (cam + lidar) >> 1, with the sum in W+1 bits (no wrap).
- **Fault counter.** Increments on each tick with diff > DIFF_THR and saturates at FAULT_TICKS. Any tick with diff ≤ DIFF_THR clears it to 0. sensor_fault_o = (count == FAULT_TICKS).
- **Window.** Circular buffer of 2^DEPTH_LOG2 entries; the write pointer wraps to 0 after the last entry.
  - Running sum is W+DEPTH_LOG2 bits: sum ← sum − buf[wp] + sample.
  - dist_o = sum >> DEPTH_LOG2.
  - A fill counter sets dist_valid_o after 2^DEPTH_LOG2 ticks. dist_valid_o stays set until reset.
- **Targets** (latched on a tick with mode_i = 1), priority order:
  1. redlight_i == 2'b11: spd_tgt = 0.
  2. crosswalk_i == 2'b11: spd_tgt = ZONE_SPEED.
  3. Otherwise: spd_tgt = speed_set_i, or DEF_SPEED when speed_set_i = 0.
  - dist_tgt = dist_set_i, or DEF_DIST when dist_set_i = 0.
- **FSM states:** ASSIST = 0, CRUISE = 1, FOLLOW = 2, STOP = 3. Transitions are evaluated on ticks, in priority order:
  1. mode_i = 0 → ASSIST (from any state).
  2. ASSIST with mode_i = 1 → CRUISE.
  3. CRUISE/FOLLOW with spd_tgt = 0 → STOP.
  4. STOP with spd_tgt ≠ 0 → CRUISE.
  5. CRUISE with (dist_valid_o and dist_o < dist_tgt) or sensor_fault_o → FOLLOW.
  6. FOLLOW with dist_o ≥ dist_tgt + H and no fault → CRUISE.
- **Outputs by state:**
  - ASSIST: {gas, brake} = 00.
  - STOP: 01.
  - FOLLOW: 01 if speed_meas_i > 0, else 11.
  - CRUISE: 01 if speed_meas_i > spd_tgt + H; 10 if speed_meas_i < spd_tgt − H; else 11.
- **Hysteresis arithmetic.** Additions use W+1 bits. spd_tgt − H clamps to 0 when spd_tgt < H.
- **Detect outputs.** redlight_o and crosswalk_o are registered and update on every tick in both modes.

## Timing
- **Reset values:** gas_o 0, brake_o 0, state_o ASSIST, dist_o 0, dist_valid_o 0, sensor_fault_o 0, redlight_o 0, crosswalk_o 0. Buffer, sum, pointer, fault counter and fill counter clear to 0. spd_tgt = DEF_SPEED, dist_tgt = DEF_DIST.
- **Reset priority.** rst wins over tick_i on the same edge. Asserting rst mid-operation clears all state at that edge.
- **Non-tick edges.** Every register holds.
- **Sample latency.** The sample taken on tick k is reflected in dist_o, dist_valid_o and sensor_fault_o right after edge k.
- **FSM inputs on tick k.** The FSM uses:
  - dist_o, dist_valid_o, sensor_fault_o, spd_tgt and dist_tgt as registered before edge k (one-tick lag);
  - mode_i, redlight_i, crosswalk_i and speed_meas_i as sampled at edge k.
- **Output timing.** gas_o/brake_o are registered and reflect the state entered at edge k.

## Configuration
- ADAS_LONG_HYST_EN defined: H = HYST in both the FOLLOW→CRUISE compare and the CRUISE speed compares.
- ADAS_LONG_HYST_EN undefined: H = 0 in those compares; the HYST parameter is ignored.

## Structure
- **Package adas_pkg:** state enum, {gas, brake} encodings (IDLE 00, ACCEL 10, BRAKE 01, HOLD 11), default target constants.
- **Sub-module adas_dist_filter:** fusion, fault counter and window. Outputs dist_o, dist_valid_o, sensor_fault_o. The FSM, targets and actuator logic stay in adas_long_ctrl.

## Test plan
- **Window fill:** defaults, cam = lidar = 40 every tick → dist_valid_o rises after the 4th tick; dist_o = 40; the 5th tick with 80 gives dist_o = 50.
- **Sensor fault:** cam = 100, lidar = 60 for 4 ticks → samples = 60; sensor_fault_o = 1 after the 4th tick; FSM goes CRUISE→FOLLOW on the next tick; one agreeing tick clears the fault.
- **Red light:** mode 1, redlight_i = 11 → spd_tgt = 0; the next tick goes to STOP with gas 0 / brake 1; redlight_i = 00 returns to CRUISE.
- **Distance hysteresis:** dist_tgt = 50, dist_o = 49 → FOLLOW.
  - With the macro: dist_o = 51 holds FOLLOW; dist_o = 52 returns to CRUISE.
  - Without the macro: dist_o = 50 returns to CRUISE.
- **Assist override:** mode_i = 0 during FOLLOW → ASSIST, gas = brake = 0 on that tick; rst asserted mid-CRUISE without a tick → all reset values at the next edge.

Source files
------------

// File: rtl/adas_pkg.sv
// ============================================================================
// Module   : adas_pkg
// Brief    : Shared types and constants for the ADAS longitudinal controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package adas_pkg;

    typedef enum logic [1:0] {
        ST_ASSIST = 2'd0,
        ST_CRUISE = 2'd1,
        ST_FOLLOW = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Actuator command as {gas, brake}
    localparam logic [1:0] c_ACT_IDLE  = 2'b00;
    localparam logic [1:0] c_ACT_ACCEL = 2'b10;
    localparam logic [1:0] c_ACT_BRAKE = 2'b01;
    localparam logic [1:0] c_ACT_HOLD  = 2'b11;

    localparam int unsigned c_DEF_SPEED  = 100;
    localparam int unsigned c_DEF_DIST   = 50;
    localparam int unsigned c_ZONE_SPEED = 20;

endpackage

`default_nettype wire

// File: rtl/adas_long_ctrl_if.sv
// ============================================================================
// Module   : adas_long_ctrl_if
// Brief    : Sensor-bus inputs and actuator outputs of the longitudinal controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface adas_long_ctrl_if #(
    parameter int W = 8
);
    logic         tick_i;
    logic         mode_i;
    logic [1:0]   redlight_i;
    logic [1:0]   crosswalk_i;
    logic [W-1:0] dist_lidar_i;
    logic [W-1:0] dist_cam_i;
    logic [W-1:0] speed_meas_i;
    logic [W-1:0] speed_set_i;
    logic [W-1:0] dist_set_i;
    logic         gas_o;
    logic         brake_o;
    logic         redlight_o;
    logic         crosswalk_o;
    logic [W-1:0] dist_o;
    logic         dist_valid_o;
    logic         sensor_fault_o;
    logic [1:0]   state_o;

    modport master (
        output tick_i, mode_i, redlight_i, crosswalk_i, dist_lidar_i, dist_cam_i,
               speed_meas_i, speed_set_i, dist_set_i,
        input  gas_o, brake_o, redlight_o, crosswalk_o, dist_o, dist_valid_o,
               sensor_fault_o, state_o
    );

    modport slave (
        input  tick_i, mode_i, redlight_i, crosswalk_i, dist_lidar_i, dist_cam_i,
               speed_meas_i, speed_set_i, dist_set_i,
        output gas_o, brake_o, redlight_o, crosswalk_o, dist_o, dist_valid_o,
               sensor_fault_o, state_o
    );
endinterface

`default_nettype wire

// File: rtl/adas_dist_filter.sv
// ============================================================================
// Module   : adas_dist_filter
// Brief    : Lidar/camera fusion, disagreement fault counter and moving-average
//            window producing the filtered following distance.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adas_dist_filter #(
    parameter int W           = 8,
    parameter int DEPTH_LOG2  = 2,
    parameter int DIFF_THR    = 20,
    parameter int FAULT_TICKS = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         tick_i,
    input  wire logic [W-1:0] dist_lidar_i,
    input  wire logic [W-1:0] dist_cam_i,
    output logic [W-1:0]      dist_o,
    output logic              dist_valid_o,
    output logic              sensor_fault_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SW    = W + DEPTH_LOG2;
    localparam int PW    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
    localparam int CW    = $clog2(FAULT_TICKS + 1);

    localparam logic [W:0]          c_THR    = (W+1)'(DIFF_THR);
    localparam logic [CW-1:0]       c_FT     = CW'(FAULT_TICKS);
    localparam logic [PW-1:0]       c_WP_MAX = PW'(DEPTH - 1);
    localparam logic [DEPTH_LOG2:0] c_DEPTH  = (DEPTH_LOG2+1)'(DEPTH);

    logic [W-1:0]      r_buf [0:DEPTH-1];
    logic [SW-1:0]     r_sum;
    logic [PW-1:0]     r_wp;
    logic [CW-1:0]     r_fault_cnt;
    logic [DEPTH_LOG2:0] r_fill;

    logic [W:0]   w_diff;
    logic [W:0]   w_pair_sum;
    logic         w_disagree;
    logic [W-1:0] w_sample;

    // Difference and pair sum are kept one bit wider so neither can wrap
    always_comb begin
        if (dist_cam_i >= dist_lidar_i)
            w_diff = {1'b0, dist_cam_i} - {1'b0, dist_lidar_i};
        else
            w_diff = {1'b0, dist_lidar_i} - {1'b0, dist_cam_i};
        w_pair_sum = {1'b0, dist_cam_i} + {1'b0, dist_lidar_i};
        w_disagree = (w_diff > c_THR);
        w_sample   = w_disagree ? dist_lidar_i : w_pair_sum[W:1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
            r_sum       <= '0;
            r_wp        <= '0;
            r_fault_cnt <= '0;
            r_fill      <= '0;
        end else if (tick_i) begin
            r_buf[r_wp] <= w_sample;
            r_sum       <= r_sum - SW'(r_buf[r_wp]) + SW'(w_sample);
            r_wp        <= (r_wp == c_WP_MAX) ? '0 : r_wp + 1'b1;
            if (!w_disagree)
                r_fault_cnt <= '0;
            else if (r_fault_cnt != c_FT)
                r_fault_cnt <= r_fault_cnt + 1'b1;
            if (r_fill != c_DEPTH)
                r_fill <= r_fill + 1'b1;
        end
    end

    assign dist_o         = r_sum[SW-1 -: W];
    assign dist_valid_o   = (r_fill == c_DEPTH);
    assign sensor_fault_o = (r_fault_cnt == c_FT);

endmodule

`default_nettype wire

// File: rtl/adas_long_ctrl.sv
// ============================================================================
// Module   : adas_long_ctrl
// Brief    : Longitudinal controller: fused distance filter, target selection
//            and a four-state FSM driving gas/brake.
//            Optional: ADAS_LONG_HYST_EN enables the HYST band in compares.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adas_long_ctrl
    import adas_pkg::*;
#(
    parameter int W           = 8,
    parameter int DEPTH_LOG2  = 2,
    parameter int DIFF_THR    = 20,
    parameter int FAULT_TICKS = 4,
    parameter int HYST        = 2,
    parameter int DEF_SPEED   = c_DEF_SPEED,
    parameter int DEF_DIST    = c_DEF_DIST,
    parameter int ZONE_SPEED  = c_ZONE_SPEED
) (
    input  wire logic        clk,
    input  wire logic        rst,
    adas_long_ctrl_if.slave  bus
);

`ifdef ADAS_LONG_HYST_EN
    localparam bit c_HYST_EN = 1'b1;
`else
    localparam bit c_HYST_EN = 1'b0;
`endif
    localparam logic [W:0] c_H = (W+1)'(c_HYST_EN ? HYST : 0);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_act;
    logic [1:0]   w_act_nxt;
    logic [W-1:0] r_spd_tgt;
    logic [W-1:0] r_dist_tgt;
    logic         r_redlight;
    logic         r_crosswalk;

    logic [W-1:0] w_dist;
    logic         w_dist_valid;
    logic         w_fault;

    adas_dist_filter #(
        .W           (W),
        .DEPTH_LOG2  (DEPTH_LOG2),
        .DIFF_THR    (DIFF_THR),
        .FAULT_TICKS (FAULT_TICKS)
    ) u_filter (
        .clk            (clk),
        .rst            (rst),
        .tick_i         (bus.tick_i),
        .dist_lidar_i   (bus.dist_lidar_i),
        .dist_cam_i     (bus.dist_cam_i),
        .dist_o         (w_dist),
        .dist_valid_o   (w_dist_valid),
        .sensor_fault_o (w_fault)
    );

    // Targets are only refreshed while autonomous
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spd_tgt   <= W'(DEF_SPEED);
            r_dist_tgt  <= W'(DEF_DIST);
            r_redlight  <= 1'b0;
            r_crosswalk <= 1'b0;
        end else if (bus.tick_i) begin
            r_redlight  <= &bus.redlight_i;
            r_crosswalk <= &bus.crosswalk_i;
            if (bus.mode_i) begin
                if (&bus.redlight_i)
                    r_spd_tgt <= '0;
                else if (&bus.crosswalk_i)
                    r_spd_tgt <= W'(ZONE_SPEED);
                else
                    r_spd_tgt <= (bus.speed_set_i == '0) ? W'(DEF_SPEED) : bus.speed_set_i;
                r_dist_tgt <= (bus.dist_set_i == '0) ? W'(DEF_DIST) : bus.dist_set_i;
            end
        end
    end

    logic [W:0] w_dist_hi;
    logic [W:0] w_spd_hi;
    logic [W:0] w_spd_lo_raw;
    logic [W:0] w_spd_lo;

    // Band edges in W+1 bits; lower speed edge clamps at 0 on borrow
    always_comb begin
        w_dist_hi    = {1'b0, r_dist_tgt} + c_H;
        w_spd_hi     = {1'b0, r_spd_tgt} + c_H;
        w_spd_lo_raw = {1'b0, r_spd_tgt} - c_H;
        w_spd_lo     = w_spd_lo_raw[W] ? '0 : w_spd_lo_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ASSIST;
            r_act   <= c_ACT_IDLE;
        end else if (bus.tick_i) begin
            r_state <= w_state_nxt;
            r_act   <= w_act_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!bus.mode_i) begin
            w_state_nxt = ST_ASSIST;
        end else begin
            case (r_state)
                ST_ASSIST: w_state_nxt = ST_CRUISE;
                ST_CRUISE: begin
                    if (r_spd_tgt == '0)
                        w_state_nxt = ST_STOP;
                    else if ((w_dist_valid && (w_dist < r_dist_tgt)) || w_fault)
                        w_state_nxt = ST_FOLLOW;
                end
                ST_FOLLOW: begin
                    if (r_spd_tgt == '0)
                        w_state_nxt = ST_STOP;
                    else if (({1'b0, w_dist} >= w_dist_hi) && !w_fault)
                        w_state_nxt = ST_CRUISE;
                end
                ST_STOP: begin
                    if (r_spd_tgt != '0)
                        w_state_nxt = ST_CRUISE;
                end
                default: w_state_nxt = ST_ASSIST;
            endcase
        end
    end

    always_comb begin
        w_act_nxt = c_ACT_IDLE;
        case (w_state_nxt)
            ST_ASSIST: w_act_nxt = c_ACT_IDLE;
            ST_STOP:   w_act_nxt = c_ACT_BRAKE;
            ST_FOLLOW: w_act_nxt = (bus.speed_meas_i != '0) ? c_ACT_BRAKE : c_ACT_HOLD;
            ST_CRUISE: begin
                if ({1'b0, bus.speed_meas_i} > w_spd_hi)
                    w_act_nxt = c_ACT_BRAKE;
                else if ({1'b0, bus.speed_meas_i} < w_spd_lo)
                    w_act_nxt = c_ACT_ACCEL;
                else
                    w_act_nxt = c_ACT_HOLD;
            end
            default: w_act_nxt = c_ACT_IDLE;
        endcase
    end

    assign bus.gas_o          = r_act[1];
    assign bus.brake_o        = r_act[0];
    assign bus.state_o        = r_state;
    assign bus.redlight_o     = r_redlight;
    assign bus.crosswalk_o    = r_crosswalk;
    assign bus.dist_o         = w_dist;
    assign bus.dist_valid_o   = w_dist_valid;
    assign bus.sensor_fault_o = w_fault;

endmodule

`default_nettype wire

// File: tb/tb_adas_long_ctrl.sv
// ============================================================================
// Module   : tb_adas_long_ctrl
// Brief    : Directed self-checking bench for adas_long_ctrl (W=8, window 4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adas_long_ctrl;

`ifdef ADAS_LONG_HYST_EN
    localparam int c_H = 2;
`else
    localparam int c_H = 0;
`endif

    localparam logic [1:0] c_S_ASSIST = 2'd0;
    localparam logic [1:0] c_S_CRUISE = 2'd1;
    localparam logic [1:0] c_S_FOLLOW = 2'd2;
    localparam logic [1:0] c_S_STOP   = 2'd3;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    adas_long_ctrl_if #(.W(8)) bus ();

    adas_long_ctrl #(
        .W(8), .DEPTH_LOG2(2), .DIFF_THR(20), .FAULT_TICKS(4), .HYST(2),
        .DEF_SPEED(100), .DEF_DIST(50), .ZONE_SPEED(20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic do_tick(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_i = 1'b1;
            @(posedge clk);
            #1;
            bus.tick_i = 1'b0;
        end
    endtask

    task automatic sens(input logic [7:0] cam, input logic [7:0] lidar);
        bus.dist_cam_i   = cam;
        bus.dist_lidar_i = lidar;
    endtask

    function automatic logic [1:0] act();
        return {bus.gas_o, bus.brake_o};
    endfunction

    initial begin
        n_pass = 0;
        n_total = 0;
        bus.tick_i = 1'b1;
        bus.mode_i = 1'b0;
        bus.redlight_i = 2'b00;
        bus.crosswalk_i = 2'b00;
        bus.speed_meas_i = 8'd100;
        bus.speed_set_i = 8'd0;
        bus.dist_set_i = 8'd0;
        sens(8'd40, 8'd40);

        // Reset with tick held high
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", bus.state_o, c_S_ASSIST);
        check("rst_act", act(), 2'b00);
        check("rst_dist", bus.dist_o, 0);
        check("rst_valid", bus.dist_valid_o, 0);
        check("rst_fault", bus.sensor_fault_o, 0);
        check("rst_red", bus.redlight_o, 0);
        bus.tick_i = 1'b0;
        rst = 1'b0;

        // Window fill in assist mode
        do_tick(3);
        check("fill3_valid", bus.dist_valid_o, 0);
        check("fill3_dist", bus.dist_o, 30);
        do_tick(1);
        check("fill4_valid", bus.dist_valid_o, 1);
        check("fill4_dist", bus.dist_o, 40);
        check("fill4_state", bus.state_o, c_S_ASSIST);
        sens(8'd80, 8'd80);
        do_tick(1);
        check("fill5_dist", bus.dist_o, 50);

        // Enter cruise, speed compares
        bus.mode_i = 1'b1;
        do_tick(1);
        check("cruise_state", bus.state_o, c_S_CRUISE);
        check("cruise_hold", act(), 2'b11);
        check("cruise_dist", bus.dist_o, 60);
        bus.speed_meas_i = 8'd130;
        do_tick(1);
        check("cruise_brake", act(), 2'b01);
        bus.speed_meas_i = 8'd50;
        do_tick(1);
        check("cruise_accel", act(), 2'b10);
        check("cruise_dist80", bus.dist_o, 80);
        bus.speed_meas_i = 8'd100;

        // Sensor disagreement: lidar used, fault after four ticks
        sens(8'd100, 8'd60);
        do_tick(3);
        check("flt3_fault", bus.sensor_fault_o, 0);
        check("flt3_dist", bus.dist_o, 65);
        do_tick(1);
        check("flt4_fault", bus.sensor_fault_o, 1);
        check("flt4_state", bus.state_o, c_S_CRUISE);
        do_tick(1);
        check("flt5_state", bus.state_o, c_S_FOLLOW);
        check("flt5_act", act(), 2'b01);
        check("flt5_fault", bus.sensor_fault_o, 1);
        sens(8'd60, 8'd60);
        bus.speed_meas_i = 8'd0;
        do_tick(1);
        check("fltclr_fault", bus.sensor_fault_o, 0);
        check("fltclr_state", bus.state_o, c_S_FOLLOW);
        check("follow_stopped", act(), 2'b11);
        bus.speed_meas_i = 8'd100;
        do_tick(1);
        check("fltclr_cruise", bus.state_o, c_S_CRUISE);

        // Distance just below target, then exactly at target
        sens(8'd49, 8'd49);
        do_tick(4);
        check("d49_dist", bus.dist_o, 49);
        check("d49_state", bus.state_o, c_S_CRUISE);
        do_tick(1);
        check("d49_follow", bus.state_o, c_S_FOLLOW);
        sens(8'd50, 8'd50);
        do_tick(4);
        check("d50_dist", bus.dist_o, 50);
        check("d50_state", bus.state_o, c_S_FOLLOW);
        do_tick(1);
        check("d50_hyst", bus.state_o, (c_H == 0) ? c_S_CRUISE : c_S_FOLLOW);
        sens(8'd60, 8'd60);
        do_tick(5);
        check("d60_cruise", bus.state_o, c_S_CRUISE);
        bus.speed_meas_i = 8'd101;
        do_tick(1);
        check("spd101", act(), (101 > 100 + c_H) ? 2'b01 : 2'b11);
        bus.speed_meas_i = 8'd100;

        // Red light: target latched, STOP one tick later
        bus.redlight_i = 2'b11;
        do_tick(1);
        check("red_o", bus.redlight_o, 1);
        check("red_lag", bus.state_o, c_S_CRUISE);
        do_tick(1);
        check("red_stop", bus.state_o, c_S_STOP);
        check("red_act", act(), 2'b01);
        bus.redlight_i = 2'b00;
        do_tick(1);
        check("red_clr_o", bus.redlight_o, 0);
        check("red_clr_lag", bus.state_o, c_S_STOP);
        do_tick(1);
        check("red_resume", bus.state_o, c_S_CRUISE);
        check("red_resume_act", act(), 2'b11);

        // Crosswalk zone speed
        bus.crosswalk_i = 2'b11;
        do_tick(1);
        check("cw_o", bus.crosswalk_o, 1);
        do_tick(1);
        check("cw_brake", act(), 2'b01);
        bus.crosswalk_i = 2'b00;
        do_tick(2);
        check("cw_clr", act(), 2'b11);
        check("cw_clr_o", bus.crosswalk_o, 0);

        // Larger distance setpoint forces FOLLOW, then assist override
        bus.dist_set_i = 8'd70;
        do_tick(1);
        check("dset_lag", bus.state_o, c_S_CRUISE);
        do_tick(1);
        check("dset_follow", bus.state_o, c_S_FOLLOW);
        bus.mode_i = 1'b0;
        do_tick(1);
        check("assist_state", bus.state_o, c_S_ASSIST);
        check("assist_act", act(), 2'b00);

        // Non-tick edges hold, then reset without a tick
        bus.mode_i = 1'b1;
        bus.dist_set_i = 8'd0;
        do_tick(1);
        check("re_cruise", bus.state_o, c_S_CRUISE);
        repeat (3) @(posedge clk);
        #1;
        check("hold_state", bus.state_o, c_S_CRUISE);
        check("hold_dist", bus.dist_o, 60);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_state", bus.state_o, c_S_ASSIST);
        check("mrst_act", act(), 2'b00);
        check("mrst_dist", bus.dist_o, 0);
        check("mrst_valid", bus.dist_valid_o, 0);
        check("mrst_fault", bus.sensor_fault_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
